csr_unit: RTL and testbench

Parametrised machine-mode CSR unit for the NPC core. It replaces the fixed four-register CSR file with Zicsr write/set/clear operations and illegal-access detection. It also performs atomic trap entry and `mret` state updates, and holds 64-bit `mcycle`/`minstret` counters. It sits beside the register file. Execute drives CSR instructions, the trap/`mret` controls and the retire pulse. Branch/PC logic consumes `mtvec_o`/`mepc_o`.

---
 rtl/csr_unit.sv | 173 +++++++++++++++++
 tb/tb_csr_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: Zicsr read/write/set/clear, trap entry and mret sequencing,
// and 64-bit mcycle/minstret counters with split-half access when XLEN is 32.
module csr_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
   parameter logic [XLEN-1:0] HART_ID      = '0,
   parameter logic [XLEN-1:0] ARCH_ID      = '0,
   parameter bit              HAS_COUNTERS = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            csr_en,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic            mret_en,
   input  logic            retire,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            mie_o
);

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam bit              HAS_HIGH   = HAS_COUNTERS && (XLEN == 32);

   csr_op_e         op;
   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
   logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic [XLEN-1:0] rdata, wval;
   logic            impl, wr;

   assign op = csr_op_e'(csr_op);

   always_comb begin
      rdata = '0;
      impl  = 1'b1;
      case (csr_addr)
         A_MSTATUS: begin
            rdata[12:11] = 2'b11;
            rdata[7]     = mpie_q;
            rdata[3]     = mie_q;
         end
         A_MTVEC:     rdata = mtvec_q;
         A_MSCRATCH:  rdata = mscratch_q;
         A_MEPC:      rdata = mepc_q;
         A_MCAUSE:    rdata = mcause_q;
         A_MCYCLE:    if (HAS_COUNTERS) rdata = mcycle_q[XLEN-1:0];   else impl = 1'b0;
         A_MINSTRET:  if (HAS_COUNTERS) rdata = minstret_q[XLEN-1:0]; else impl = 1'b0;
         A_MCYCLEH:   if (HAS_HIGH) rdata = XLEN'(mcycle_q[63:32]);   else impl = 1'b0;
         A_MINSTRETH: if (HAS_HIGH) rdata = XLEN'(minstret_q[63:32]); else impl = 1'b0;
         A_MVENDORID: rdata = '0;
         A_MARCHID:   rdata = ARCH_ID;
         A_MHARTID:   rdata = HART_ID;
         default:     impl = 1'b0;
      endcase
   end

   assign csr_rdata   = rdata;
   assign csr_illegal = csr_en & (~impl | ((op != OP_READ) & (csr_addr[11:10] == 2'b11)));
   assign wr          = csr_en & ~csr_illegal & (op != OP_READ);

   always_comb begin
      case (op)
         OP_WRITE: wval = csr_wdata;
         OP_SET:   wval = rdata | csr_wdata;
         OP_CLEAR: wval = rdata & ~csr_wdata;
         default:  wval = rdata;
      endcase
   end

   // Counters advance by default; trap/mret only suppress the CSR write, never the count.
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, retire};
      if (trap_en) begin
         mepc_d   = trap_pc & ALIGN_MASK;
         mcause_d = trap_cause;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_en) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (wr) begin
         case (csr_addr)
            A_MSTATUS: begin
               mie_d  = wval[3];
               mpie_d = wval[7];
            end
            A_MTVEC:    mtvec_d    = wval & ALIGN_MASK;
            A_MSCRATCH: mscratch_d = wval;
            A_MEPC:     mepc_d     = wval & ALIGN_MASK;
            A_MCAUSE:   mcause_d   = wval;
            A_MCYCLE: begin
               mcycle_d             = mcycle_q;
               mcycle_d[XLEN-1:0]   = wval;
            end
            A_MINSTRET: begin
               minstret_d           = minstret_q;
               minstret_d[XLEN-1:0] = wval;
            end
            A_MCYCLEH: begin
               mcycle_d               = mcycle_q;
               mcycle_d[63:64-XLEN]   = wval;
            end
            A_MINSTRETH: begin
               minstret_d             = minstret_q;
               minstret_d[63:64-XLEN] = wval;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   assign mtvec_o = mtvec_q;
   assign mepc_o  = mepc_q;
   assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit (XLEN=32): directed scenarios plus randomized traffic checked
// against a field-level reference model of the machine-mode CSRs.
module tb_csr_unit;

   localparam logic [31:0] MTVEC_RST = 32'h8000_0107;
   localparam logic [31:0] HART      = 32'h0000_0005;
   localparam logic [31:0] ARCH      = 32'h0000_001A;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csr_en = 1'b0;
   logic [1:0]  csr_op = '0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_en = 1'b0;
   logic [31:0] trap_pc = '0;
   logic [31:0] trap_cause = '0;
   logic        mret_en = 1'b0;
   logic        retire = 1'b0;
   logic [31:0] mtvec_o, mepc_o;
   logic        mie_o;

   csr_unit #(
      .XLEN        (32),
      .MTVEC_RESET (MTVEC_RST),
      .HART_ID     (HART),
      .ARCH_ID     (ARCH),
      .HAS_COUNTERS(1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .csr_en     (csr_en),
      .csr_op     (csr_op),
      .csr_addr   (csr_addr),
      .csr_wdata  (csr_wdata),
      .csr_rdata  (csr_rdata),
      .csr_illegal(csr_illegal),
      .trap_en    (trap_en),
      .trap_pc    (trap_pc),
      .trap_cause (trap_cause),
      .mret_en    (mret_en),
      .retire     (retire),
      .mtvec_o    (mtvec_o),
      .mepc_o     (mepc_o),
      .mie_o      (mie_o)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference state, kept as architectural fields
   bit          m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
   logic [63:0] m_cyc, m_ins;

   task automatic ref_reset();
      m_mie = 0; m_mpie = 0;
      m_mtvec = MTVEC_RST & ~32'd3;
      m_mscratch = '0; m_mepc = '0; m_mcause = '0;
      m_cyc = '0; m_ins = '0;
   endtask

   // {implemented, value}
   function automatic logic [32:0] ref_read(input logic [11:0] a);
      case (a)
         12'h300: return {1'b1, 19'd0, 2'b11, 3'd0, m_mpie, 3'd0, m_mie, 3'd0};
         12'h305: return {1'b1, m_mtvec};
         12'h340: return {1'b1, m_mscratch};
         12'h341: return {1'b1, m_mepc};
         12'h342: return {1'b1, m_mcause};
         12'hB00: return {1'b1, m_cyc[31:0]};
         12'hB02: return {1'b1, m_ins[31:0]};
         12'hB80: return {1'b1, m_cyc[63:32]};
         12'hB82: return {1'b1, m_ins[63:32]};
         12'hF11: return {1'b1, 32'd0};
         12'hF12: return {1'b1, ARCH};
         12'hF14: return {1'b1, HART};
         default: return {1'b0, 32'd0};
      endcase
   endfunction

   task automatic cycle(input logic en, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wd, input logic trap, input logic [31:0] pc,
                        input logic [31:0] cause, input logic mret, input logic ret,
                        input logic [32:0] want, input string tag);
      logic [32:0] r;
      logic        legal;
      logic [31:0] old, nv;
      logic [63:0] c0, i0;
      csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd;
      trap_en = trap; trap_pc = pc; trap_cause = cause; mret_en = mret; retire = ret;
      r     = ref_read(addr);
      old   = r[31:0];
      legal = r[32] && !(op != 2'b00 && addr[11:10] == 2'b11);
      #1;
      chk("rdata", csr_rdata, old);
      chk("illegal", {31'd0, csr_illegal}, {31'd0, en && !legal});
      chk("mtvec_o", mtvec_o, m_mtvec);
      chk("mepc_o", mepc_o, m_mepc);
      chk("mie_o", {31'd0, mie_o}, {31'd0, m_mie});
      if (want[32]) chk(tag, csr_rdata, want[31:0]);
      @(posedge clk);
      c0 = m_cyc; i0 = m_ins;
      m_cyc = m_cyc + 64'd1;
      m_ins = m_ins + (ret ? 64'd1 : 64'd0);
      if (trap) begin
         m_mepc = pc & ~32'd3; m_mcause = cause; m_mpie = m_mie; m_mie = 0;
      end else if (mret) begin
         m_mie = m_mpie; m_mpie = 1;
      end else if (en && legal && op != 2'b00) begin
         nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
         case (addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec = nv & ~32'd3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'd3;
            12'h342: m_mcause = nv;
            12'hB00: m_cyc = {c0[63:32], nv};
            12'hB80: m_cyc = {nv, c0[31:0]};
            12'hB02: m_ins = {i0[63:32], nv};
            12'hB82: m_ins = {nv, i0[31:0]};
            default: ;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
      cycle(1, op, a, wd, 0, '0, '0, 0, 0, '0, "");
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] want, input string tag);
      cycle(1, 2'b00, a, '0, 0, '0, '0, 0, 0, {1'b1, want}, tag);
   endtask

   task automatic idle(input logic ret);
      cycle(0, 2'b00, 12'h000, '0, 0, '0, '0, 0, ret, '0, "");
   endtask

   logic [11:0] addrs [15] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                               12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF14,
                               12'h7C0, 12'h301, 12'hB03};

   initial begin
      logic [11:0] a;
      ref_reset();
      repeat (2) @(negedge clk);
      chk("rst_mtvec_o", mtvec_o, 32'h8000_0104);
      chk("rst_mepc_o", mepc_o, 32'h0);
      chk("rst_mie_o", {31'd0, mie_o}, 32'd0);
      rst_n = 1'b1;

      rd(12'h300, 32'h0000_1800, "mstatus_rst");
      rd(12'h305, 32'h8000_0104, "mtvec_rst");

      csr(2'b01, 12'h340, 32'hDEAD_BEEF);
      rd(12'h340, 32'hDEAD_BEEF, "mscratch_wr");
      csr(2'b10, 12'h340, 32'h0000_000F);
      rd(12'h340, 32'hDEAD_BEEF, "mscratch_set");
      csr(2'b11, 12'h340, 32'hF000_0000);
      rd(12'h340, 32'h0EAD_BEEF, "mscratch_clr");

      csr(2'b10, 12'h300, 32'h8);
      cycle(0, 2'b00, 12'h000, '0, 1, 32'h8000_0102, 32'd11, 0, 0, '0, "");
      chk("trap_mepc_o", mepc_o, 32'h8000_0100);
      chk("trap_mie_o", {31'd0, mie_o}, 32'd0);
      rd(12'h342, 32'd11, "trap_mcause");
      rd(12'h300, 32'h0000_1880, "trap_mstatus");
      cycle(0, 2'b00, 12'h000, '0, 0, '0, '0, 1, 0, '0, "");
      rd(12'h300, 32'h0000_1888, "mret_mstatus");
      chk("mret_mie_o", {31'd0, mie_o}, 32'd1);

      cycle(1, 2'b01, 12'h305, 32'h1234, 1, 32'h0000_0040, 32'd2, 0, 0, '0, "");
      rd(12'h305, 32'h8000_0104, "trap_prio_mtvec");
      rd(12'h341, 32'h0000_0040, "trap_prio_mepc");

      csr(2'b01, 12'hF14, 32'hFFFF_FFFF);
      rd(12'hF14, HART, "hartid_ro");
      rd(12'h7C0, 32'h0, "unimpl_read");

      csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
      csr(2'b01, 12'hB80, 32'h0);
      idle(0);
      rd(12'hB80, 32'd1, "mcycleh_carry");
      csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
      csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
      idle(0);
      rd(12'hB80, 32'd0, "mcycle_wrap");

      csr(2'b01, 12'hB02, 32'h0);
      csr(2'b01, 12'hB82, 32'h0);
      repeat (5) idle(1);
      rd(12'hB02, 32'd5, "minstret_5");

      for (int i = 0; i < 400; i++) begin
         a = (i % 8 == 7) ? 12'($urandom) : addrs[$urandom_range(0, 14)];
         cycle($urandom_range(0, 9) < 7, 2'($urandom), a, $urandom,
               $urandom_range(0, 15) == 0, $urandom, $urandom,
               $urandom_range(0, 15) == 0, 1'($urandom), '0, "");
      end

      csr_en = 1'b0; trap_en = 1'b0; mret_en = 1'b0; retire = 1'b0;
      csr_addr = 12'hB00;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mcycle", csr_rdata, 32'h0);
      chk("async_rst_mtvec_o", mtvec_o, 32'h8000_0104);
      ref_reset();
      @(negedge clk);
      rst_n = 1'b1;
      rd(12'hB02, 32'h0, "post_rst_minstret");
      rd(12'hB00, 32'h1, "post_rst_mcycle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
